// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer host-link command decoder.
// Holds the SUMP-style opcode values, the decoder state encoding and the
// long-command payload length.
package la_pkg;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_TRIG_MASK = 8'hC0;
  localparam logic [7:0] OP_TRIG_VAL  = 8'hC1;
  localparam logic [7:0] OP_COUNTS    = 8'h81;
  localparam logic [7:0] OP_FLAGS     = 8'h82;

  localparam int PAYLOAD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    EXEC    = 2'd2
  } state_e;

endpackage

// File: rtl/la_rise_detect.sv
// Registered rising-edge detector for a held-level ready signal.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   level - level-type ready input (may stay high for many cycles)
//   rise  - high for exactly one cycle when level goes from 0 to 1
module la_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/la_cmd_decoder.sv
// Command controller for the logic-analyzer host link. Assembles bytes from
// the 4x-oversampling UART receiver into SUMP-style commands, writes the
// capture configuration registers and issues one-cycle control strobes.
// Ports:
//   CLKP4      - 4x-baud clock shared with the UART receiver
//   RST        - asynchronous active-high reset
//   RxData     - received byte, stable while RxReady is high
//   RxReady    - byte-valid level from the UART
//   RxEn       - receiver enable; dropped for one cycle with ResetPulse
//   TrigMask   - trigger mask register
//   TrigValue  - trigger value register
//   ReadCount  - samples to read back after the trigger
//   DelayCount - post-trigger delay in samples
//   Flags      - capture flags register
//   ResetPulse - strobe on opcode 0x00
//   ArmPulse   - strobe on opcode 0x01
//   IdReq      - strobe on opcode 0x02
//   CmdError   - strobe on unknown opcode or inter-byte timeout
module la_cmd_decoder
  import la_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TW          = 12
) (
  input  logic        CLKP4,
  input  logic        RST,
  input  logic [7:0]  RxData,
  input  logic        RxReady,
  output logic        RxEn,
  output logic [31:0] TrigMask,
  output logic [31:0] TrigValue,
  output logic [15:0] ReadCount,
  output logic [15:0] DelayCount,
  output logic [7:0]  Flags,
  output logic        ResetPulse,
  output logic        ArmPulse,
  output logic        IdReq,
  output logic        CmdError
);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX   = {TW{1'b1}};
  localparam logic [1:0]    LAST_IDX = 2'(PAYLOAD_BYTES - 1);

  logic accept;

  state_e        state_q,       state_d;
  logic [7:0]    op_q,          op_d;
  logic [1:0]    idx_q,         idx_d;
  logic [TW-1:0] to_cnt_q,      to_cnt_d;
  logic [TW-1:0] to_cnt_inc;
  logic [31:0]   payload_q,     payload_d;
  logic [31:0]   trig_mask_q,   trig_mask_d;
  logic [31:0]   trig_value_q,  trig_value_d;
  logic [15:0]   read_count_q,  read_count_d;
  logic [15:0]   delay_count_q, delay_count_d;
  logic [7:0]    flags_q,       flags_d;
  logic          reset_pulse_q, reset_pulse_d;
  logic          arm_pulse_q,   arm_pulse_d;
  logic          id_req_q,      id_req_d;
  logic          cmd_error_q,   cmd_error_d;
  logic          rx_en_q,       rx_en_d;

  // One accept per byte no matter how long the UART holds RxReady.
  la_rise_detect u_rx_rise (
    .clk   (CLKP4),
    .rst   (RST),
    .level (RxReady),
    .rise  (accept)
  );

  // Saturating so a stalled frame can never wrap back below the limit.
  assign to_cnt_inc = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    idx_d         = idx_q;
    to_cnt_d      = to_cnt_q;
    payload_d     = payload_q;
    trig_mask_d   = trig_mask_q;
    trig_value_d  = trig_value_q;
    read_count_d  = read_count_q;
    delay_count_d = delay_count_q;
    flags_d       = flags_q;
    reset_pulse_d = 1'b0;
    arm_pulse_d   = 1'b0;
    id_req_d      = 1'b0;
    cmd_error_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        idx_d    = '0;
        if (accept) begin
          if (!RxData[7]) begin
            unique case (RxData)
              OP_RESET: reset_pulse_d = 1'b1;
              OP_ARM:   arm_pulse_d   = 1'b1;
              OP_ID:    id_req_d      = 1'b1;
              default:  cmd_error_d   = 1'b1;
            endcase
          end else begin
            op_d      = RxData;
            payload_d = '0;
            state_d   = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
          // Little-endian: first payload byte ends up in bits [7:0].
          payload_d = {RxData, payload_q[31:8]};
          to_cnt_d  = '0;
          idx_d     = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            state_d = EXEC;
          end
        end else if (to_cnt_inc == TO_LAST) begin
          // The error strobe lands exactly TIMEOUT_CYC cycles after the
          // last accepted byte.
          cmd_error_d = 1'b1;
          to_cnt_d    = '0;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end

      EXEC: begin
        unique case (op_q)
          OP_TRIG_MASK: trig_mask_d  = payload_q;
          OP_TRIG_VAL:  trig_value_d = payload_q;
          OP_COUNTS: begin
            read_count_d  = payload_q[15:0];
            delay_count_d = payload_q[31:16];
          end
          OP_FLAGS:     flags_d      = payload_q[7:0];
          default:      cmd_error_d  = 1'b1;
        endcase
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Dropping the enable alongside ResetPulse resynchronises the receiver.
    rx_en_d = ~reset_pulse_d;
  end

  always_ff @(posedge CLKP4 or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      op_q          <= '0;
      idx_q         <= '0;
      to_cnt_q      <= '0;
      payload_q     <= '0;
      trig_mask_q   <= '0;
      trig_value_q  <= '0;
      read_count_q  <= '0;
      delay_count_q <= '0;
      flags_q       <= '0;
      reset_pulse_q <= 1'b0;
      arm_pulse_q   <= 1'b0;
      id_req_q      <= 1'b0;
      cmd_error_q   <= 1'b0;
      rx_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      idx_q         <= idx_d;
      to_cnt_q      <= to_cnt_d;
      payload_q     <= payload_d;
      trig_mask_q   <= trig_mask_d;
      trig_value_q  <= trig_value_d;
      read_count_q  <= read_count_d;
      delay_count_q <= delay_count_d;
      flags_q       <= flags_d;
      reset_pulse_q <= reset_pulse_d;
      arm_pulse_q   <= arm_pulse_d;
      id_req_q      <= id_req_d;
      cmd_error_q   <= cmd_error_d;
      rx_en_q       <= rx_en_d;
    end
  end

  assign RxEn       = rx_en_q;
  assign TrigMask   = trig_mask_q;
  assign TrigValue  = trig_value_q;
  assign ReadCount  = read_count_q;
  assign DelayCount = delay_count_q;
  assign Flags      = flags_q;
  assign ResetPulse = reset_pulse_q;
  assign ArmPulse   = arm_pulse_q;
  assign IdReq      = id_req_q;
  assign CmdError   = cmd_error_q;

endmodule
